// File: rtl/tensor_pkg.sv
// tensor_pkg: shared sizes, controller state encoding and slice helper
// for the tensor_stream_ctrl block.
package tensor_pkg;

    localparam int TENSOR_N = 64;
    localparam int TENSOR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT_DONE,
        RELEASE,
        DRAIN
    } state_e;

    // Low bit position of element idx inside a packed N*W array.
    function automatic int unsigned slice_lo(
        input int unsigned idx,
        input int unsigned w
    );
        return idx * w;
    endfunction

endpackage

// File: rtl/tensor_elem_buf.sv
// tensor_elem_buf: N x W register bank with single-element write,
// full parallel load, packed read-out and one indexed read port.
module tensor_elem_buf
    import tensor_pkg::*;
#(
    parameter int N = TENSOR_N,
    parameter int W = TENSOR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] widx,
    input  logic [W-1:0]         wdata,
    input  logic                 load,
    input  logic [N*W-1:0]       ldata,
    input  logic [$clog2(N)-1:0] ridx,
    output logic [W-1:0]         rdata,
    output logic [N*W-1:0]       q
);

    logic [N*W-1:0] mem_q, mem_d;

    // Next bank contents: parallel load wins over a single-element write.
    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d = ldata;
        end else if (we) begin
            mem_d[slice_lo(32'(widx), W) +: W] = wdata;
        end
    end

    // Bank storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[slice_lo(32'(ridx), W) +: W];
    assign q     = mem_q;

endmodule

// File: rtl/tensor_stream_ctrl.sv
// tensor_stream_ctrl: streams A then B into tensor_proc, runs its start/done
// handshake and drains the result. Optional wait timeout: TENSOR_CTRL_TIMEOUT_EN.
module tensor_stream_ctrl
    import tensor_pkg::*;
#(
    parameter int N       = TENSOR_N,
    parameter int W       = TENSOR_W,
    parameter int TIMEOUT = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic           s_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic           core_start,
    input  logic           core_done,
    output logic [N*W-1:0] core_a,
    output logic [N*W-1:0] core_b,
    input  logic [N*W-1:0] core_result,
    output logic           busy,
    output logic           err,
    input  logic           err_clr
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          core_start_q, core_start_d;
    logic          err_q, err_d;

    logic          hs_in, hs_out, final_b, r_load, tmo;
    logic [W-1:0]  r_rd;
    logic [W-1:0]  a_rd_unused, b_rd_unused;
    logic [N*W-1:0] r_q_unused;

    assign s_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign m_valid = (state_q == DRAIN);
    assign m_data  = m_valid ? r_rd : '0;
    assign m_last  = m_valid && (idx_q == LAST);
    assign hs_in   = s_valid && s_ready;
    assign hs_out  = m_valid && m_ready;
    assign final_b = (state_q == LOAD_B) && (idx_q == LAST);
    assign r_load  = (state_q == WAIT_DONE) && core_done && !tmo;

    assign core_start = core_start_q;
    assign err        = err_q;
    // Idle covers the one-cycle IDLE state after reset as well as LOAD_A at 0.
    assign busy = !((state_q == IDLE) ||
                    ((state_q == LOAD_A) && (idx_q == '0)));

`ifdef TENSOR_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;

    // Wait counter: cleared entering WAIT_DONE, runs through WAIT_DONE/RELEASE.
    always_comb begin
        wcnt_d = wcnt_q;
        tmo    = 1'b0;
        if (state_q == START) begin
            wcnt_d = '0;
        end else if ((state_q == WAIT_DONE) || (state_q == RELEASE)) begin
            if (wcnt_q == CW'(TIMEOUT - 1)) begin
                tmo = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    // Controller next-state, index, core_start and sticky error.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        core_start_d = core_start_q;
        unique case (state_q)
            IDLE: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
            LOAD_A: begin
                if (hs_in) begin
                    if (idx_q == LAST) begin
                        state_d = LOAD_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (hs_in) begin
                    if (idx_q == LAST) begin
                        state_d = START;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            START: begin
                core_start_d = 1'b1;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                core_start_d = 1'b1;
                if (core_done) begin
                    core_start_d = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                core_start_d = 1'b0;
                if (!core_done) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (hs_out) begin
                    if (idx_q == LAST) begin
                        state_d = LOAD_A;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                idx_d        = '0;
                core_start_d = 1'b0;
            end
        endcase
        if (tmo) begin
            state_d      = IDLE;
            idx_d        = '0;
            core_start_d = 1'b0;
        end
        // A new violation outranks a clear in the same cycle.
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if ((hs_in && (s_last != final_b)) || tmo) begin
            err_d = 1'b1;
        end
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
        end
    end

    tensor_elem_buf #(.N(N), .W(W)) u_buf_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (hs_in && (state_q == LOAD_A)),
        .widx  (idx_q),
        .wdata (s_data),
        .load  (1'b0),
        .ldata ('0),
        .ridx  (idx_q),
        .rdata (a_rd_unused),
        .q     (core_a)
    );

    tensor_elem_buf #(.N(N), .W(W)) u_buf_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (hs_in && (state_q == LOAD_B)),
        .widx  (idx_q),
        .wdata (s_data),
        .load  (1'b0),
        .ldata ('0),
        .ridx  (idx_q),
        .rdata (b_rd_unused),
        .q     (core_b)
    );

    tensor_elem_buf #(.N(N), .W(W)) u_buf_r (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (1'b0),
        .widx  ('0),
        .wdata ('0),
        .load  (r_load),
        .ldata (core_result),
        .ridx  (idx_q),
        .rdata (r_rd),
        .q     (r_q_unused)
    );

endmodule
